// File: rtl/rv32v_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32v_types_pkg
// Shared types for the two-lane vector execute stage.
//   VL_WIDTH    : element-index width (2**VL_WIDTH >= VLMAX = 128)
//   OFFSET_W    : width of an element offset inside one destination register
//   sew_t       : element width code (SEW_8, SEW_16, SEW_32)
//   offset_t    : element offset within a destination register
//   seq_state_t : element sequencer states (IDLE, RUN, DONE0)
// ---------------------------------------------------------------------------
package rv32v_types_pkg;

    localparam int VLEN_DEF = 128;
    localparam int VL_WIDTH = 7;
    localparam int OFFSET_W = $clog2(VLEN_DEF / 8);

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2
    } sew_t;

    typedef logic [OFFSET_W-1:0] offset_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE0 = 2'd2
    } seq_state_t;

    // Effective destination width code: a widening op writes 2*SEW elements.
    // A result of 3 (64-bit) never comes from decode but is still handled.
    function automatic logic [1:0] effWidth(input sew_t s, input logic widen);
        return 2'(s) + {1'b0, widen};
    endfunction

endpackage

// File: rtl/rv32v_elem_sequencer_if.sv
// ---------------------------------------------------------------------------
// rv32v_elem_sequencer_if
// Groups the decode handshake, hazard controls and lane-side pair outputs of
// the element sequencer.
//   master : decode / hazard side (drives instruction + stall/flush)
//   slave  : the sequencer (drives in_ready and the per-lane pair outputs)
// Signals:
//   in_valid/in_ready, vl, vstart, sew, vd_widen  : instruction handoff
//   stall, flush                                   : hazard unit controls
//   out_valid, wen, elem_idx0/1, woffset0/1,
//   vreg_off0/1, last, busy                        : pair presented to lanes
// ---------------------------------------------------------------------------
interface rv32v_elem_sequencer_if #(
    parameter int VL_WIDTH = rv32v_types_pkg::VL_WIDTH
);
    import rv32v_types_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         vl;
    logic [31:0]         vstart;
    sew_t                sew;
    logic                vd_widen;
    logic                stall;
    logic                flush;
    logic                out_valid;
    logic [1:0]          wen;
    logic [VL_WIDTH-1:0] elem_idx0;
    logic [VL_WIDTH-1:0] elem_idx1;
    offset_t             woffset0;
    offset_t             woffset1;
    logic [2:0]          vreg_off0;
    logic [2:0]          vreg_off1;
    logic                last;
    logic                busy;

    modport master (
        output in_valid, vl, vstart, sew, vd_widen, stall, flush,
        input  in_ready, out_valid, wen, elem_idx0, elem_idx1,
               woffset0, woffset1, vreg_off0, vreg_off1, last, busy
    );

    modport slave (
        input  in_valid, vl, vstart, sew, vd_widen, stall, flush,
        output in_ready, out_valid, wen, elem_idx0, elem_idx1,
               woffset0, woffset1, vreg_off0, vreg_off1, last, busy
    );

endinterface

// File: rtl/rv32v_elem_offset.sv
// ---------------------------------------------------------------------------
// rv32v_elem_offset
// Splits an absolute element index into (register within the LMUL group,
// element slot within that register) for effective width code e.
// Elements per register is VLEN/(8<<e), a power of two, so the split is a
// shift and a mask.
// Ports:
//   idx_i      : absolute element index
//   e_i        : effective width code (0=8b, 1=16b, 2=32b, 3=64b)
//   woffset_o  : idx mod elements-per-register
//   vreg_off_o : idx / elements-per-register (register offset in the group)
// ---------------------------------------------------------------------------
module rv32v_elem_offset #(
    parameter int VLEN     = 128,
    parameter int VL_WIDTH = rv32v_types_pkg::VL_WIDTH
) (
    input  logic [VL_WIDTH-1:0]      idx_i,
    input  logic [1:0]               e_i,
    output rv32v_types_pkg::offset_t woffset_o,
    output logic [2:0]               vreg_off_o
);
    import rv32v_types_pkg::*;

    localparam int OFF_W = $clog2(VLEN / 8);

    logic [2:0]          shAmt;
    logic [VL_WIDTH-1:0] mask;

    // log2(elements per register) = log2(VLEN/8) - e; the low bits of the
    // index select the slot and the remaining bits select the register.
    always_comb begin
        shAmt      = 3'(OFF_W) - {1'b0, e_i};
        mask       = VL_WIDTH'((1 << shAmt) - 1);
        woffset_o  = offset_t'(idx_i & mask);
        vreg_off_o = 3'(idx_i >> shAmt);
    end

endmodule

// File: rtl/rv32v_elem_sequencer.sv
// ---------------------------------------------------------------------------
// rv32v_elem_sequencer
// Per-instruction element sequencer for the two-lane vector execute stage.
// Accepts one instruction's length configuration and then presents element
// pairs (idx, idx+1) from vstart up to vl-1, one pair per cycle.
// Ports:
//   CLK          : clock
//   nRST         : synchronous active-low reset
//   bus          : rv32v_elem_sequencer_if.slave (handshake, stall/flush,
//                  per-lane wen / element index / offsets, last, busy)
//   stall_cycles : cycles spent with busy & stall, saturating
//                  (only when RV32V_SEQ_STALL_CNT_EN is defined)
// Configuration macro: RV32V_SEQ_STALL_CNT_EN
// ---------------------------------------------------------------------------
module rv32v_elem_sequencer #(
    parameter int VLEN     = 128,
    parameter int VL_WIDTH = rv32v_types_pkg::VL_WIDTH
) (
    input  logic                 CLK,
    input  logic                 nRST,
`ifdef RV32V_SEQ_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    rv32v_elem_sequencer_if.slave bus
);
    import rv32v_types_pkg::*;

    localparam int CW = VL_WIDTH + 1;

    seq_state_t          state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       vl_q, vl_d;
    sew_t                sew_q, sew_d;
    logic                widen_q, widen_d;

    logic [CW:0]         idxPlus1;
    logic [CW:0]         idxPlus2;
    logic [CW:0]         vlExt;
    logic                runLast;
    logic                inReady;
    logic                outValid;
    logic [1:0]          wen;
    logic                lastPair;
    logic [VL_WIDTH-1:0] laneIdx0;
    logic [VL_WIDTH-1:0] laneIdx1;
    logic [1:0]          eCode;
    logic                unused_hi;

    // Only the low VL_WIDTH+1 bits of vl/vstart carry meaning.
    assign unused_hi = ^{bus.vl[31:CW], bus.vstart[31:CW]};

    // Comparisons are done one bit wider so idx+2 can never wrap past vl.
    assign vlExt    = {1'b0, vl_q};
    assign idxPlus1 = {1'b0, idx_q} + 1'b1;
    assign idxPlus2 = {1'b0, idx_q} + 2'd2;
    assign runLast  = (idxPlus2 >= vlExt);

    // Next-state and pair outputs. Flush overrides everything, including an
    // instruction that would otherwise be accepted this cycle; an accept in
    // the final RUN or DONE0 cycle reloads directly so no bubble appears.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vl_d     = vl_q;
        sew_d    = sew_q;
        widen_d  = widen_q;
        inReady  = 1'b0;
        outValid = 1'b0;
        wen      = 2'b00;
        lastPair = 1'b0;

        case (state_q)
            IDLE: begin
                inReady = 1'b1;
            end
            RUN: begin
                outValid = 1'b1;
                wen      = {(idxPlus1 < vlExt), 1'b1};
                lastPair = runLast;
                inReady  = runLast && !bus.stall;
                if (!bus.stall) begin
                    if (runLast) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idxPlus2[CW-1:0];
                    end
                end
            end
            DONE0: begin
                outValid = 1'b1;
                lastPair = 1'b1;
                inReady  = !bus.stall;
                if (!bus.stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d  = IDLE;
            idx_d    = idx_q;
            inReady  = 1'b0;
            outValid = 1'b0;
            wen      = 2'b00;
        end else if (inReady && bus.in_valid) begin
            vl_d    = bus.vl[CW-1:0];
            idx_d   = bus.vstart[CW-1:0];
            sew_d   = bus.sew;
            widen_d = bus.vd_widen;
            state_d = (bus.vstart[CW-1:0] >= bus.vl[CW-1:0]) ? DONE0 : RUN;
        end
    end

    // State and latched instruction fields.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vl_q    <= '0;
            sew_q   <= SEW_8;
            widen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
            sew_q   <= sew_d;
            widen_q <= widen_d;
        end
    end

    // Index outputs read as zero while idle so stale indices never leak out.
    assign laneIdx0 = (state_q == IDLE) ? '0 : idx_q[VL_WIDTH-1:0];
    assign laneIdx1 = (state_q == IDLE) ? '0 : idxPlus1[VL_WIDTH-1:0];
    assign eCode    = effWidth(sew_q, widen_q);

    rv32v_elem_offset #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_off0 (
        .idx_i      (laneIdx0),
        .e_i        (eCode),
        .woffset_o  (bus.woffset0),
        .vreg_off_o (bus.vreg_off0)
    );

    rv32v_elem_offset #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) u_off1 (
        .idx_i      (laneIdx1),
        .e_i        (eCode),
        .woffset_o  (bus.woffset1),
        .vreg_off_o (bus.vreg_off1)
    );

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.wen       = wen;
    assign bus.last      = lastPair;
    assign bus.busy      = (state_q != IDLE);
    assign bus.elem_idx0 = laneIdx0;
    assign bus.elem_idx1 = laneIdx1;

`ifdef RV32V_SEQ_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    // Performance counter: cycles the sequencer is occupied but held by the
    // hazard unit. Sticks at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stallCnt_q <= '0;
        end else if ((state_q != IDLE) && bus.stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cycles = stallCnt_q;
`endif

endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32v_elem_sequencer
// Self-checking bench for rv32v_elem_sequencer. A pair-queue model expands
// each accepted instruction into the list of pairs it must produce; one
// compare process checks the DUT against the head of that queue every cycle.
// Directed stimulus adds hand-computed literal expectations.
// Honours RV32V_SEQ_STALL_CNT_EN for the stall_cycles output.
// ---------------------------------------------------------------------------
module tb_rv32v_elem_sequencer;
    import rv32v_types_pkg::*;

    localparam int TB_VLEN = 128;

    typedef struct {
        int         i0;
        int         i1;
        logic [1:0] wen;
        logic       last;
        int         e;
    } pair_t;

    logic        clk;
    logic        nRST;
    logic [31:0] stallCycles;
    int          checks;
    int          failures;
    pair_t       expQ[$];
    logic [31:0] expStallCnt;

    rv32v_elem_sequencer_if bus ();

    rv32v_elem_sequencer dut (
        .CLK          (clk),
        .nRST         (nRST),
`ifdef RV32V_SEQ_STALL_CNT_EN
        .stall_cycles (stallCycles),
`endif
        .bus          (bus)
    );

`ifndef RV32V_SEQ_STALL_CNT_EN
    assign stallCycles = '0;
`endif

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic iv, input int vlv, input int vs,
                                 input sew_t s, input logic w,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid = iv;
        bus.vl       = vlv;
        bus.vstart   = vs;
        bus.sew      = s;
        bus.vd_widen = w;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic idleCycle(input logic st);
        applyStimulus(1'b0, 0, 0, SEW_8, 1'b0, st, 1'b0);
    endtask

    // Expand an accepted instruction into every pair it must present.
    task automatic pushInstr(input int vlv, input int vs, input int e);
        pair_t p;
        p.e = e;
        if (vs >= vlv) begin
            p.i0 = vs; p.i1 = vs + 1; p.wen = 2'b00; p.last = 1'b1;
            expQ.push_back(p);
        end else begin
            for (int i = vs; i < vlv; i += 2) begin
                p.i0   = i;
                p.i1   = i + 1;
                p.wen  = {(i + 1 < vlv), 1'b1};
                p.last = (i + 2 >= vlv);
                expQ.push_back(p);
            end
        end
    endtask

    function automatic int eprOf(input int e);
        return TB_VLEN / (8 << e);
    endfunction

    // Compare process: checks outputs at each falling edge against the pair
    // queue, then advances the model for the coming rising edge.
    initial begin
        pair_t p;
        bit    expBusy, expReady, expValid;
        expStallCnt = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            expBusy  = (expQ.size() != 0);
            expReady = !bus.flush && (!expBusy || (expQ.size() == 1 && !bus.stall));
            expValid = expBusy && !bus.flush;
            checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
            checkOutput("busy", 32'(bus.busy), 32'(expBusy));
            if (expValid) begin
                p = expQ[0];
                checkOutput("wen", 32'(bus.wen), 32'(p.wen));
                checkOutput("last", 32'(bus.last), 32'(p.last));
                if (p.wen[0]) begin
                    checkOutput("elem_idx0", 32'(bus.elem_idx0), p.i0 % 128);
                    checkOutput("woffset0", 32'(bus.woffset0), p.i0 % eprOf(p.e));
                    checkOutput("vreg_off0", 32'(bus.vreg_off0), (p.i0 / eprOf(p.e)) % 8);
                end
                if (p.wen[1]) begin
                    checkOutput("elem_idx1", 32'(bus.elem_idx1), p.i1 % 128);
                    checkOutput("woffset1", 32'(bus.woffset1), p.i1 % eprOf(p.e));
                    checkOutput("vreg_off1", 32'(bus.vreg_off1), (p.i1 / eprOf(p.e)) % 8);
                end
            end else begin
                checkOutput("wen_quiet", 32'(bus.wen), 32'd0);
            end
`ifdef RV32V_SEQ_STALL_CNT_EN
            checkOutput("stall_cycles", stallCycles, expStallCnt);
`endif
            if (!nRST) begin
                expQ.delete();
                expStallCnt = '0;
            end else begin
                if (expBusy && bus.stall && expStallCnt != 32'hFFFF_FFFF)
                    expStallCnt = expStallCnt + 1;
                if (bus.flush) begin
                    expQ.delete();
                end else begin
                    if (expBusy && !bus.stall) void'(expQ.pop_front());
                    if (bus.in_valid && expReady)
                        pushInstr(int'(bus.vl[7:0]), int'(bus.vstart[7:0]),
                                  int'(bus.sew) + int'(bus.vd_widen));
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with literal expectations.
    initial begin
        checks = 0;
        failures = 0;
        nRST = 1'b0;
        bus.in_valid = 1'b0; bus.vl = '0; bus.vstart = '0; bus.sew = SEW_8;
        bus.vd_widen = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;

        // Reset values
        idleCycle(1'b0);
        idleCycle(1'b0);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_last", 32'(bus.last), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_idx1", 32'(bus.elem_idx1), 32'd0);
        checkOutput("rst_woff1", 32'(bus.woffset1), 32'd0);
        checkOutput("rst_vreg1", 32'(bus.vreg_off1), 32'd0);
        idleCycle(1'b0);
        nRST = 1'b1;

        // vl=5, SEW_32: pairs (0,1) (2,3) (4,-)
        applyStimulus(1'b1, 5, 0, SEW_32, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t1_wen_p0", 32'(bus.wen), 32'd3);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t1_wen_p1", 32'(bus.wen), 32'd3);
        checkOutput("t1_last_p1", 32'(bus.last), 32'd0);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t1_wen_p2", 32'(bus.wen), 32'd1);
        checkOutput("t1_last_p2", 32'(bus.last), 32'd1);
        checkOutput("t1_ready_p2", 32'(bus.in_ready), 32'd1);
        checkOutput("t1_vreg_p2", 32'(bus.vreg_off0), 32'd1);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t1_idle", 32'(bus.out_valid), 32'd0);

        // vl=40, SEW_8 widened (epr=8): pair (16,17) in register 2
        applyStimulus(1'b1, 40, 0, SEW_8, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            idleCycle(1'b0); @(negedge clk);
            if (k == 8) begin
                checkOutput("t2_idx0", 32'(bus.elem_idx0), 32'd16);
                checkOutput("t2_vreg0", 32'(bus.vreg_off0), 32'd2);
                checkOutput("t2_woff0", 32'(bus.woffset0), 32'd0);
                checkOutput("t2_woff1", 32'(bus.woffset1), 32'd1);
            end
        end

        // vstart == vl: one DONE0 cycle then idle
        applyStimulus(1'b1, 6, 6, SEW_16, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t3_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t3_wen", 32'(bus.wen), 32'd0);
        checkOutput("t3_last", 32'(bus.last), 32'd1);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t3_busy_after", 32'(bus.busy), 32'd0);

        // Stall 3 cycles on pair (2,3)
        applyStimulus(1'b1, 8, 0, SEW_16, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        for (int k = 0; k < 4; k++) begin
            idleCycle(k < 3); @(negedge clk);
            checkOutput("t4_hold_idx0", 32'(bus.elem_idx0), 32'd2);
        end
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t4_next_idx0", 32'(bus.elem_idx0), 32'd4);
        idleCycle(1'b0);
        idleCycle(1'b0);

        // Back-to-back: second instruction accepted on the last pair
        applyStimulus(1'b1, 3, 0, SEW_32, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        applyStimulus(1'b1, 4, 1, SEW_8, 1'b0, 1'b0, 1'b0); @(negedge clk);
        checkOutput("t5_ready_last", 32'(bus.in_ready), 32'd1);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t5_b_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t5_b_idx0", 32'(bus.elem_idx0), 32'd1);
        idleCycle(1'b0);
        idleCycle(1'b0);

        // Flush on pair (2,3) while stalled
        applyStimulus(1'b1, 10, 0, SEW_32, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b1);
        applyStimulus(1'b0, 0, 0, SEW_8, 1'b0, 1'b1, 1'b1); @(negedge clk);
        checkOutput("t6_flush_wen", 32'(bus.wen), 32'd0);
        checkOutput("t6_flush_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6_flush_ready", 32'(bus.in_ready), 32'd0);
        idleCycle(1'b1); @(negedge clk);
        checkOutput("t6_after_busy", 32'(bus.busy), 32'd0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Reset mid-instruction
        applyStimulus(1'b1, 10, 0, SEW_32, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);
        nRST = 1'b0;
        idleCycle(1'b0);
        nRST = 1'b1;
        @(negedge clk);
        checkOutput("t7_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("t7_rst_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 2, 0, SEW_32, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0); @(negedge clk);
        checkOutput("t7_new_wen", 32'(bus.wen), 32'd3);
        checkOutput("t7_new_last", 32'(bus.last), 32'd1);
        idleCycle(1'b0);
        idleCycle(1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
